// File: rtl/rf_wb_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rf_wb_arbiter
// Purpose  : Two-requester writeback arbiter for a single register-file write
//            port, with a per-register pending-write scoreboard.
// Option   : RF_WB_COALESCE_EN merges same-address requests into one A write.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rf_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              hold,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [NREG-1:0]   busy,
  output logic              grant_last
);

  logic              w_grant_a;
  logic              w_grant_b;
  logic              rf_we_q,      rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q,   rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q,   rf_wdata_d;
  logic              grant_last_q, grant_last_d;

  // B is the older instruction, so a same-address collision must let B write first
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (!reset && !hold) begin
      if (a_valid && b_valid) begin
        if (a_addr == b_addr) begin
`ifdef RF_WB_COALESCE_EN
          w_grant_a = 1'b1;
          w_grant_b = 1'b1;
`else
          w_grant_b = 1'b1;
`endif
        end else if (grant_last_q) begin
          w_grant_a = 1'b1;
        end else begin
          w_grant_b = 1'b1;
        end
      end else begin
        w_grant_a = a_valid;
        w_grant_b = b_valid;
      end
    end
  end

  // A takes precedence in the data mux so a coalesced pair writes A's value
  always_comb begin
    rf_we_d      = w_grant_a | w_grant_b;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    grant_last_d = grant_last_q;
    if (w_grant_a) begin
      rf_waddr_d   = a_addr;
      rf_wdata_d   = a_data;
      grant_last_d = 1'b0;
    end else if (w_grant_b) begin
      rf_waddr_d   = b_addr;
      rf_wdata_d   = b_data;
      grant_last_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      grant_last_q <= 1'b1;
    end else begin
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      grant_last_q <= grant_last_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
      assign busy[gi] = !reset &&
                        ((a_valid && (a_addr     == ADDR_W'(gi))) ||
                         (b_valid && (b_addr     == ADDR_W'(gi))) ||
                         (rf_we_q && (rf_waddr_q == ADDR_W'(gi))));
    end
  endgenerate

  assign a_ready    = w_grant_a;
  assign b_ready    = w_grant_b;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign grant_last = grant_last_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_rf_wb_arbiter
// Purpose  : Directed vector bench for rf_wb_arbiter (RF_WB_COALESCE_EN aware).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rf_wb_arbiter;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREG   = 8;
  localparam int NVEC   = 18;

  logic              clk = 1'b0;
  logic              reset, hold;
  logic              a_valid, b_valid;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_ready, b_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [NREG-1:0]   busy;
  logic              grant_last;

  int n_checks = 0;
  int n_errors = 0;

  rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .hold(hold),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .grant_last(grant_last)
  );

  always #5 clk = ~clk;

  // Inputs applied in a cycle; ar/br/busy seen before the edge, the rest after it
  typedef struct {
    logic              rst, hld, av, bv;
    logic [ADDR_W-1:0] aa, ba;
    logic [DATA_W-1:0] ad, bd;
    logic              ar, br;
    logic [NREG-1:0]   bsy;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              gl;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic rst, hld, av, input logic [2:0] aa, input logic [15:0] ad,
    input logic bv, input logic [2:0] ba, input logic [15:0] bd,
    input logic ar, br, input logic [7:0] bsy,
    input logic we, input logic [2:0] wa, input logic [15:0] wd, input logic gl);
    vec_t v;
    v.rst = rst; v.hld = hld; v.av = av; v.aa = aa; v.ad = ad;
    v.bv = bv; v.ba = ba; v.bd = bd; v.ar = ar; v.br = br; v.bsy = bsy;
    v.we = we; v.wa = wa; v.wd = wd; v.gl = gl;
    return v;
  endfunction

  task automatic chk(input string name, input int row,
                     input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
    end
  endtask

  task automatic drive(input logic rst, hld, av, input logic [2:0] aa,
                       input logic [15:0] ad, input logic bv,
                       input logic [2:0] ba, input logic [15:0] bd);
    reset = rst; hold = hld; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);

    // Reset with A requesting: no ready, busy forced low
    vecs[0]  = mk(1,0, 1,3,16'h0034, 0,0,16'h0000, 0,0,8'h00, 0,0,16'h0000,1);
    vecs[1]  = mk(1,0, 1,3,16'h0034, 0,0,16'h0000, 0,0,8'h00, 0,0,16'h0000,1);
    vecs[2]  = mk(0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,8'h00, 0,0,16'h0000,1);
    // Single-requester latency, then idle and a lone B
    vecs[3]  = mk(0,0, 1,3,16'h0034, 0,0,16'h0000, 1,0,8'h08, 1,3,16'h0034,0);
    vecs[4]  = mk(0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,8'h08, 0,3,16'h0034,0);
    vecs[5]  = mk(0,0, 0,0,16'h0000, 1,5,16'h5555, 0,1,8'h20, 1,5,16'h5555,1);
    // Round-robin A=2 / B=7
    vecs[6]  = mk(0,0, 1,2,16'h0202, 1,7,16'h0707, 1,0,8'hA4, 1,2,16'h0202,0);
    vecs[7]  = mk(0,0, 1,2,16'h0202, 1,7,16'h0707, 0,1,8'h84, 1,7,16'h0707,1);
    vecs[8]  = mk(0,0, 1,2,16'h0202, 1,7,16'h0707, 1,0,8'h84, 1,2,16'h0202,0);
    vecs[9]  = mk(0,0, 1,2,16'h0202, 1,7,16'h0707, 0,1,8'h84, 1,7,16'h0707,1);
    // Hold freezes grants
    vecs[10] = mk(0,1, 1,2,16'h0202, 1,7,16'h0707, 0,0,8'h84, 0,7,16'h0707,1);
    vecs[11] = mk(0,1, 1,2,16'h0202, 1,7,16'h0707, 0,0,8'h84, 0,7,16'h0707,1);
    vecs[12] = mk(0,1, 1,2,16'h0202, 1,7,16'h0707, 0,0,8'h84, 0,7,16'h0707,1);
`ifdef RF_WB_COALESCE_EN
    vecs[13] = mk(0,0, 1,1,16'h00AA, 1,1,16'h00BB, 1,1,8'h02, 1,1,16'h00AA,0);
    vecs[14] = mk(0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,8'h02, 0,1,16'h00AA,0);
    vecs[15] = mk(0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,8'h00, 0,1,16'h00AA,0);
`else
    vecs[13] = mk(0,0, 1,1,16'h00AA, 1,1,16'h00BB, 0,1,8'h02, 1,1,16'h00BB,1);
    vecs[14] = mk(0,0, 1,1,16'h00AA, 0,0,16'h0000, 1,0,8'h02, 1,1,16'h00AA,0);
    vecs[15] = mk(0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,8'h02, 0,1,16'h00AA,0);
`endif
    // Register 0 is writable; then grant_last=0 sends a split pair to B
    vecs[16] = mk(0,0, 1,0,16'hFFFF, 0,0,16'h0000, 1,0,8'h01, 1,0,16'hFFFF,0);
    vecs[17] = mk(0,0, 1,4,16'h4444, 1,6,16'h6666, 0,1,8'h51, 1,6,16'h6666,1);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].hld, vecs[i].av, vecs[i].aa, vecs[i].ad,
            vecs[i].bv, vecs[i].ba, vecs[i].bd);
      #1;
      chk("a_ready", i, 32'(a_ready), 32'(vecs[i].ar));
      chk("b_ready", i, 32'(b_ready), 32'(vecs[i].br));
      chk("busy",    i, 32'(busy),    32'(vecs[i].bsy));
      @(posedge clk);
      #1;
      chk("rf_we",      i, 32'(rf_we),      32'(vecs[i].we));
      chk("rf_waddr",   i, 32'(rf_waddr),   32'(vecs[i].wa));
      chk("rf_wdata",   i, 32'(rf_wdata),   32'(vecs[i].wd));
      chk("grant_last", i, 32'(grant_last), 32'(vecs[i].gl));
    end

    // Mid-operation reset: A granted, B left waiting, then reset drops B
    @(negedge clk);
    drive(0, 0, 1, 3'd2, 16'h0202, 1, 3'd7, 16'h0707);
    #1;
    chk("mid_a_ready", 100, 32'(a_ready), 32'd1);
    @(negedge clk);
    drive(1, 0, 0, 3'd0, 16'h0000, 1, 3'd7, 16'h0707);
    #1;
    chk("rst_b_ready", 101, 32'(b_ready), 32'd0);
    chk("rst_busy",    101, 32'(busy),    32'd0);
    @(posedge clk);
    #1;
    chk("rst_gl",    101, 32'(grant_last), 32'd1);
    chk("rst_we",    101, 32'(rf_we),      32'd0);
    chk("rst_waddr", 101, 32'(rf_waddr),   32'd0);
    @(negedge clk);
    drive(0, 0, 1, 3'd3, 16'h0333, 1, 3'd5, 16'h0555);
    #1;
    chk("post_a_ready", 102, 32'(a_ready), 32'd1);
    chk("post_b_ready", 102, 32'(b_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("post_waddr", 102, 32'(rf_waddr), 32'd3);
    chk("post_wdata", 102, 32'(rf_wdata), 32'h0333);

    // Round-robin straight out of reset: A, B, A, B with a write every cycle
    @(negedge clk);
    drive(1, 0, 1, 3'd2, 16'h0202, 1, 3'd7, 16'h0707);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("rr_we",    200 + k, 32'(rf_we),    32'd1);
      chk("rr_waddr", 200 + k, 32'(rf_waddr), (k % 2 == 0) ? 32'd2 : 32'd7);
    end

    @(negedge clk);
    drive(0, 0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters.
- Requester A is the ALU/execute result. Requester B is the memory/load result, which is always the older instruction.
- Arbitrates with valid/ready handshakes and drives a registered write port (we, addr, data) into the register file.
- Publishes a per-register pending-write scoreboard that decode uses for hazard stalls.

Parameters:
- DATA_W, 16, width of write data.
- ADDR_W, 3, width of the register address.
- NREG, 8, number of registers; must equal 2**ADDR_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  requester A has a write pending.
- a_addr  in  ADDR_W  destination register for A.
- a_data  in  DATA_W  write data for A.
- a_ready  out  1  A's request is accepted this cycle (combinational).
- b_valid  in  1  requester B has a write pending.
- b_addr  in  ADDR_W  destination register for B.
- b_data  in  DATA_W  write data for B.
- b_ready  out  1  B's request is accepted this cycle (combinational).
- hold  in  1  freezes arbitration; no grants are issued.
- rf_we  out  1  register file write enable (registered).
- rf_waddr  out  ADDR_W  register file write address (registered).
- rf_wdata  out  DATA_W  register file write data (registered).
- busy  out  NREG  busy[i]=1 while a write to register i is pending or in flight.
- grant_last  out  1  0 = A was granted last, 1 = B was granted last (round-robin pointer).

Behaviour:
- Reset (synchronous, cycle after reset sampled high): rf_we=0, rf_waddr=0, rf_wdata=0, grant_last=1 (A has priority next), busy=0. While reset=1, a_ready=b_ready=0.
- Requests present during reset are dropped, not queued. Requesters must re-present them after reset deasserts.
- Handshake:
  - A transfer happens when valid & ready in the same cycle.
  - Requesters hold addr and data stable until ready.
  - ready is never asserted without the matching valid.
- Latency: a transfer accepted in cycle N produces rf_we=1 with that addr and data in cycle N+1, for exactly one cycle.
- In any cycle without a transfer, rf_we=0 in the next cycle. rf_waddr and rf_wdata hold their previous values.
- Arbitration (combinational, one grant per cycle):
  - hold=1: no grant; a_ready=b_ready=0.
  - Only one requester valid: grant it.
  - Both valid, a_addr==b_addr: grant B, because B is the older instruction and write order must be preserved. A is granted on a later cycle.
  - Both valid, different addresses: round-robin. Grant A if grant_last=1, else grant B.
- grant_last updates on every grant: 0 after an A grant, 1 after a B grant. It is unchanged when there is no grant.
- Scoreboard: busy[i] = (a_valid & a_addr==i) | (b_valid & b_addr==i) | (rf_we & rf_waddr==i). It is purely combinational and is forced to 0 while reset=1.
- Starvation bound: with both requesters continuously valid at different addresses, neither waits more than 1 cycle between grants.
- Writes to register 0 are not special; every address is writable.

Optional Feature:
- Macro: RF_WB_COALESCE_EN.
- Defined: when both requesters are valid, a_addr==b_addr and hold=0, both a_ready and b_ready assert in the same cycle.
  - Only A's data is written next cycle, because A is the younger instruction and overwrites B's value.
  - grant_last is set to 0.
- Not defined: sequential behaviour as above. B is written first, then A on the following grant.

Test Plan:
- Reset check: reset high 2 cycles with a_valid=1 -> a_ready=0; afterwards rf_we=0, rf_waddr=0, rf_wdata=0, busy=8'h00, grant_last=1.
- Single requester latency: a_valid=1, a_addr=3, a_data=16'h0034 at cycle N -> a_ready=1 at N; rf_we=1, rf_waddr=3, rf_wdata=16'h0034 at N+1; busy[3]=1 at N and at N+1.
- Round-robin: A addr 2 and B addr 7 continuously valid from reset -> grant order A, B, A, B; rf_waddr sequence 2, 7, 2, 7.
- Same-address ordering (macro off): A addr 1 data 16'h00AA, B addr 1 data 16'h00BB together -> write 00BB at N+1, then 00AA at N+2. Final rf_wdata=16'h00AA.
- Coalescing (macro on): same stimulus -> a_ready=b_ready=1 in cycle N; a single write of addr 1, data 16'h00AA at N+1; rf_we=0 at N+2.
- Hold and mid-operation reset: hold=1 with both valid for 3 cycles -> no ready, rf_we=0. Then reset pulsed while B is waiting -> B dropped, grant_last=1, and the first grant after reset goes to A.
